// File: rtl/mpu_bus_sync_pkg.sv
// rtl/mpu_bus_sync_pkg.sv - shared widths and FSM state encoding for the MCU bus front end
//
// Purpose : common definitions imported by the interface and the top module.
// Contents: default address/data widths, error counter width, 2-bit FSM state type.

package mpu_bus_sync_pkg;

  localparam int MPU_ADDR_WIDTH          = 16;
  localparam int MPU_DATA_WIDTH          = 16;
  localparam int MPU_BUS_ERR_COUNT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_HOLD  = 2'd3
  } mpu_state_t;

endpackage

// File: rtl/mpu_bus_sync_if.sv
// rtl/mpu_bus_sync_if.sv - MCU pin and core MPU port bundle for mpu_bus_sync
//
// Purpose : groups the MCU-side pins and the core-side MPU port into one bundle.
// Modports:
//   slave  - the bridge: takes MCU pins and core read data, drives core strobes,
//            address/data, MCU wait and read-data/output-enable.
//   master - the environment (MCU + core) view, directions reversed.
// All strobes, wait and byte enables are active low (leading underscore).

interface mpu_bus_sync_if
  import mpu_bus_sync_pkg::*;
#(
  parameter int ADDR_WIDTH = MPU_ADDR_WIDTH,
  parameter int DATA_WIDTH = MPU_DATA_WIDTH
);

  logic                  _mcu_en;
  logic                  _mcu_rd;
  logic                  _mcu_wr;
  logic [1:0]            _mcu_be;
  logic [ADDR_WIDTH-1:0] mcu_addr;
  logic [DATA_WIDTH-1:0] mcu_data_in;
  logic [DATA_WIDTH-1:0] mcu_data_out;
  logic                  mcu_data_oe;
  logic                  _mcu_wait;
  logic                  _core_en;
  logic                  _core_rd;
  logic                  _core_wr;
  logic [1:0]            _core_be;
  logic [ADDR_WIDTH-1:0] core_addr;
  logic [DATA_WIDTH-1:0] core_data_out;
  logic [DATA_WIDTH-1:0] core_data_in;

  modport slave (
    input  _mcu_en, _mcu_rd, _mcu_wr, _mcu_be, mcu_addr, mcu_data_in, core_data_in,
    output mcu_data_out, mcu_data_oe, _mcu_wait,
    output _core_en, _core_rd, _core_wr, _core_be, core_addr, core_data_out
  );

  modport master (
    output _mcu_en, _mcu_rd, _mcu_wr, _mcu_be, mcu_addr, mcu_data_in, core_data_in,
    input  mcu_data_out, mcu_data_oe, _mcu_wait,
    input  _core_en, _core_rd, _core_wr, _core_be, core_addr, core_data_out
  );

endinterface

// File: rtl/bit_synchronizer.sv
// rtl/bit_synchronizer.sv - multi-flop single-bit synchroniser with async active-low reset
//
// Purpose : brings one asynchronous level into the clk domain.
// Ports   : clk, rst_n (async, active low), d (async in), q (synchronised out).
// Params  : STAGES (>=2 flops), RESET_VALUE (value of every flop in reset).

module bit_synchronizer #(
  parameter int   STAGES      = 2,
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VALUE}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/mpu_bus_sync.sv
// rtl/mpu_bus_sync.sv - MCU strobe synchroniser and single-access bridge to the core MPU port
//
// Purpose : synchronises the async MCU strobes, latches addr/data/byte enables and
//           issues exactly one core access per MCU strobe, returning read data
//           with an active-low wait handshake.
// Ports   : clk, _reset (async, active low), bus (mpu_bus_sync_if.slave).
//           With MPU_BUS_ERR_EN defined: err_clear (in), err_count (out, 8 bits),
//           a saturating count of rd+wr protocol errors.
// Params  : ADDR_WIDTH, DATA_WIDTH, SYNC_STAGES (>=2), READ_LATENCY (1..15).

module mpu_bus_sync
  import mpu_bus_sync_pkg::*;
#(
  parameter int ADDR_WIDTH   = MPU_ADDR_WIDTH,
  parameter int DATA_WIDTH   = MPU_DATA_WIDTH,
  parameter int SYNC_STAGES  = 2,
  parameter int READ_LATENCY = 1
) (
  input  logic clk,
  input  logic _reset,
  mpu_bus_sync_if.slave bus
`ifdef MPU_BUS_ERR_EN
  ,
  input  logic                               err_clear,
  output logic [MPU_BUS_ERR_COUNT_WIDTH-1:0] err_count
`endif
);

  logic s_en, s_rd, s_wr;
  logic rd_req, wr_req;

  bit_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_en (
    .clk(clk), .rst_n(_reset), .d(bus._mcu_en), .q(s_en));
  bit_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_rd (
    .clk(clk), .rst_n(_reset), .d(bus._mcu_rd), .q(s_rd));
  bit_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_wr (
    .clk(clk), .rst_n(_reset), .d(bus._mcu_wr), .q(s_wr));

  // Both strobes low matches neither request, so the FSM stays in IDLE.
  assign rd_req = ~s_en & ~s_rd &  s_wr;
  assign wr_req = ~s_en & ~s_wr &  s_rd;

  mpu_state_t            state, next_state;
  logic [3:0]            lat_cnt;
  logic                  lat_done;
  logic                  last_rd;
  logic                  core_en_d, core_rd_d, core_wr_d;
  logic                  core_en_q, core_rd_q, core_wr_q, wait_q;
  logic [1:0]            core_be_q;
  logic [ADDR_WIDTH-1:0] core_addr_q;
  logic [DATA_WIDTH-1:0] core_wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  assign lat_done = (lat_cnt == 4'(READ_LATENCY - 1));

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Strobes are decoded from next_state and registered, so they change on the
  // same edge as the state and cannot glitch on state-decode transitions.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: begin
        if (wr_req) begin
          next_state = ST_WRITE;
        end else if (rd_req) begin
          next_state = ST_READ;
        end
      end
      ST_WRITE: next_state = ST_HOLD;
      ST_READ:  if (lat_done) next_state = ST_HOLD;
      ST_HOLD: begin
        // Wait for the MCU to drop this strobe so a long strobe is one access.
        if (s_en || (last_rd ? s_rd : s_wr)) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
    core_wr_d = (next_state != ST_WRITE);
    core_rd_d = (next_state != ST_READ);
    core_en_d = core_wr_d & core_rd_d;
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      core_en_q    <= 1'b1;
      core_rd_q    <= 1'b1;
      core_wr_q    <= 1'b1;
      wait_q       <= 1'b1;
      core_be_q    <= 2'b11;
      core_addr_q  <= '0;
      core_wdata_q <= '0;
      rdata_q      <= '0;
      lat_cnt      <= '0;
      last_rd      <= 1'b0;
    end else begin
      core_en_q <= core_en_d;
      core_rd_q <= core_rd_d;
      core_wr_q <= core_wr_d;
      wait_q    <= core_en_d;
      // Latch only when an access starts; held stable until the next one.
      if (state == ST_IDLE && (rd_req || wr_req)) begin
        core_addr_q  <= bus.mcu_addr;
        core_be_q    <= bus._mcu_be;
        core_wdata_q <= bus.mcu_data_in;
        last_rd      <= rd_req;
      end
      if (state == ST_READ) begin
        lat_cnt <= lat_cnt + 4'd1;
        if (lat_done) rdata_q <= bus.core_data_in;
      end else begin
        lat_cnt <= '0;
      end
    end
  end

  assign bus._core_en      = core_en_q;
  assign bus._core_rd      = core_rd_q;
  assign bus._core_wr      = core_wr_q;
  assign bus._core_be      = core_be_q;
  assign bus.core_addr     = core_addr_q;
  assign bus.core_data_out = core_wdata_q;
  assign bus._mcu_wait     = wait_q;
  assign bus.mcu_data_out  = rdata_q;
  // Raw pin gating releases the data bus as soon as the MCU turns it around.
  assign bus.mcu_data_oe   = (state == ST_HOLD) & last_rd & ~bus._mcu_rd;

`ifdef MPU_BUS_ERR_EN
  logic                               err_cond, err_cond_q;
  logic [MPU_BUS_ERR_COUNT_WIDTH-1:0] err_cnt_q;

  assign err_cond = ~s_en & ~s_rd & ~s_wr;

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      err_cond_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      err_cond_q <= err_cond;
      if (err_clear) begin
        err_cnt_q <= '0;
      end else if (err_cond && !err_cond_q && !(&err_cnt_q)) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule
